syncfifo: RTL and testbench

Single-clock, parametrised FIFO: the same-clock counterpart and successor to the team's dual-clock FIFO, used where producer and consumer share one clock. Supports arbitrary (non-power-of-two) depth, a registered occupancy count, programmable almost-full/almost-empty thresholds, and optional sticky overflow/underflow error flags. Intended for intra-domain rate buffering between pipeline stages and in front of stream interfaces.

---
 rtl/syncfifo.sv | 153 +++++++++++++++
 tb/tb_syncfifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/syncfifo.sv
// syncfifo: single-clock FIFO, any depth, registered count and flags.
// Optional sticky overflow/underflow flags under SYNCFIFO_ERRFLAGS_EN.
`timescale 1ns/1ps
module syncfifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic wr_acc;
    logic rd_acc;

    // Gating by registered flags: no same-cycle write-to-read bypass.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flags come from next-count so they always agree with count.
    always_comb begin
        full_d   = (count_d == CNT_MAX);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;

`ifdef SYNCFIFO_ERRFLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A set event in the same cycle as err_clr keeps the flag high.
    always_comb begin
        ovf_d = (wr_en & full_q) | (ovf_q & ~err_clr);
        unf_d = (rd_en & empty_q) | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_syncfifo.sv
// tb_syncfifo: directed + random checks of syncfifo against a queue model.
// Expects sticky error flags only when SYNCFIFO_ERRFLAGS_EN is defined.
`timescale 1ns/1ps
module tb_syncfifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AFT   = 3;
    localparam int AET   = 2;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef SYNCFIFO_ERRFLAGS_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    int tests = 0;
    int fails = 0;

    syncfifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AFULL_THRESH(AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .err_clr(err_clr),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, occupancy is its size.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_rd  = '0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        bit f, e;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                mq.delete();
                m_rd  = '0;
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                f = (mq.size() == DEPTH);
                e = (mq.size() == 0);
                if (ERR) begin
                    m_ovf = (wr_en && f) || (m_ovf && !err_clr);
                    m_unf = (rd_en && e) || (m_unf && !err_clr);
                end
                if (rd_en && !e) m_rd = mq.pop_front();
                if (wr_en && !f) mq.push_back(wr_data);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                chk("cnt", 32'(count), 32'(mq.size()));
                chk("cnt_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
                chk("full", 32'(full), 32'(mq.size() == DEPTH));
                chk("empty", 32'(empty), 32'(mq.size() == 0));
                chk("afull", 32'(almost_full), 32'(mq.size() >= AFT));
                chk("aempty", 32'(almost_empty), 32'(mq.size() <= AET));
                chk("rd_data", 32'(rd_data), 32'(m_rd));
                chk("ovf", 32'(overflow), 32'(m_ovf));
                chk("unf", 32'(underflow), 32'(m_unf));
            end
        end
    end

    task automatic cyc(input bit w, input logic [WIDTH-1:0] d,
                       input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // fill 0x10..0x14
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_afull", 32'(almost_full), 32'd1);

        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd5);
        chk("ovf_set", 32'(overflow), 32'(ERR));
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_hold", 32'(overflow), 32'(ERR));
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // full + wr + rd: read wins, write dropped
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        chk("simf_count", 32'(count), 32'd4);
        chk("simf_rd", 32'(rd_data), 32'h10);
        chk("simf_full", 32'(full), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 1; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_rd", 32'(rd_data), 32'(8'h10 + i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("wrap_afull", 32'(almost_full), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_rd", 32'(rd_data), 32'(8'h20 + i));
        end
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);

        // underflow set wins over simultaneous clear
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_set", 32'(underflow), 32'(ERR));
        chk("unf_rd_hold", 32'(rd_data), 32'h22);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_clr", 32'(underflow), 32'd0);

        // empty + wr + rd: write accepted, read rejected
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        chk("sime_count", 32'(count), 32'd1);
        chk("sime_rd", 32'(rd_data), 32'h22);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        cyc(1'b1, 8'h34, 1'b0, 1'b0);
        cyc(1'b1, 8'h35, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);

        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_rd", 32'(rd_data), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_rd", 32'(rd_data), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 100; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
